ifetch_buffer: RTL and testbench

Instruction-fetch stage directly downstream of the program-counter register. Owns the sequential fetch PC and issues instruction-memory reads with a req/ack handshake. Buffers returned instructions, tagged with their PC, in a small FIFO feeding decode through a valid/ready handshake. Taken branches and jumps redirect the fetch PC and flush the FIFO; any in-flight read is discarded.

---
 rtl/ifetch_buffer_if.sv | 29 ++
 rtl/ifetch_buffer.sv | 184 ++++++++++++++++++
 tb/tb_ifetch_buffer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_buffer_if.sv
// ifetch_buffer_if
// Bundle of the fetch stage's external handshakes: redirect input,
// instruction-memory req/ack read port and the valid/ready decode port.
// The fetch stage is the master of this bundle; the memory/decode side
// (or a testbench) uses the slave modport.
interface ifetch_buffer_if #(
   parameter int WIDTH = 32
);
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [WIDTH-1:0] imem_rdata;
   logic             inst_valid;
   logic [WIDTH-1:0] inst;
   logic [WIDTH-1:0] inst_pc;
   logic             inst_ready;

   modport master (
      input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer
// Instruction-fetch stage: owns the sequential fetch PC, issues one
// instruction-memory read at a time (req/ack), and queues returned words
// tagged with their PC in a DEPTH-entry FIFO feeding decode (valid/ready).
// A redirect reloads the fetch PC and flushes the FIFO; a read that is in
// flight at that moment is allowed to finish and its data is dropped.
//
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN
//   defined   -> adds output fetch_misalign; a redirect to a non word-aligned
//                address sets it sticky until reset and stops further fetching.
//   undefined -> redirect_pc[1:0] is treated as 2'b00.
module ifetch_buffer #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
`ifdef IFETCH_MISALIGN_CHECK_EN
   output logic                   fetch_misalign,
`endif
   ifetch_buffer_if.master        bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // no request outstanding
      S_BUSY = 2'd1,   // request outstanding, data will be kept
      S_DROP = 2'd2    // request outstanding, data will be discarded
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_fetch_pc;
   logic [WIDTH-1:0] w_fetch_pc_next;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] w_addr_next;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_mem_inst [DEPTH];
   logic [WIDTH-1:0] r_mem_pc   [DEPTH];

   logic             w_inst_valid;
   logic             w_pop;
   logic             w_push;
   logic             w_flush;
   logic             w_issue_ok;
   logic [WIDTH-1:0] w_redirect_pc;
   logic [WIDTH-1:0] w_fetch_pc_plus4;
   logic [CW-1:0]    w_count_after;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic             r_misalign;

   // A misaligned target is kept as-is; the sticky flag blocks any fetch from it.
   assign w_redirect_pc  = bus.redirect_pc;
   assign w_issue_ok     = ~r_misalign;
   assign fetch_misalign = r_misalign;

   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end
`else
   logic             w_unused_lsbs;

   // Instructions are word aligned, so the two low target bits are ignored.
   assign w_redirect_pc = {bus.redirect_pc[WIDTH-1:2], 2'b00};
   assign w_issue_ok    = 1'b1;
   assign w_unused_lsbs = ^bus.redirect_pc[1:0];
`endif

   assign w_inst_valid     = (r_count != '0);
   assign w_pop            = w_inst_valid & bus.inst_ready;
   assign w_fetch_pc_plus4 = r_fetch_pc + WIDTH'(4);
   // Occupancy after this cycle's push (assumed) and pop; decides back-to-back issue.
   assign w_count_after    = r_count + CW'(1) - CW'(w_pop);

   assign bus.imem_req   = (r_state != S_IDLE);
   assign bus.imem_addr  = r_addr;
   assign bus.inst_valid = w_inst_valid;
   assign bus.inst       = r_mem_inst[r_rd_ptr];
   assign bus.inst_pc    = r_mem_pc[r_rd_ptr];

   // Request FSM: next state, next fetch PC / request address, push and flush.
   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_addr_next     = r_addr;
      w_push          = 1'b0;
      w_flush         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.redirect) begin
               w_fetch_pc_next = w_redirect_pc;
               w_flush         = 1'b1;
            end else if ((r_count < DEPTH_C) && w_issue_ok) begin
               w_state_next = S_BUSY;
               w_addr_next  = r_fetch_pc;
            end
         end
         S_BUSY: begin
            if (bus.redirect) begin
               w_fetch_pc_next = w_redirect_pc;
               w_flush         = 1'b1;
               // Without an ack the old request stays on the bus until it completes.
               w_state_next    = bus.imem_ack ? S_IDLE : S_DROP;
            end else if (bus.imem_ack) begin
               w_push          = 1'b1;
               w_fetch_pc_next = w_fetch_pc_plus4;
               if (w_count_after < DEPTH_C) begin
                  w_addr_next = w_fetch_pc_plus4;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (bus.redirect) begin
               w_fetch_pc_next = w_redirect_pc;
               w_flush         = 1'b1;
            end
            if (bus.imem_ack) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // FSM state, fetch PC and outstanding request address.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_addr     <= w_addr_next;
      end
   end

   // FIFO pointers and occupancy; a flush wins over a coincident pop.
   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // FIFO storage: cleared on reset, written at the tail on push.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_inst[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer
// Directed scenarios followed by a randomized run. A memory model answers
// reads with a fixed function of the address; a stream model predicts the
// PCs decode must see (sequential from reset/redirect target) and a monitor
// compares every accepted instruction against it.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (adds the misalign scenario).
module tb_ifetch_buffer;

   localparam int          WIDTH    = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          SEG_LEN  = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   ifetch_buffer_if #(.WIDTH(WIDTH)) bus ();

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic fetch_misalign;
`endif

   ifetch_buffer #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
`ifdef IFETCH_MISALIGN_CHECK_EN
      .fetch_misalign (fetch_misalign),
`endif
      .bus            (bus)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int n_pops = 0;

   // Instruction memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stream model + monitor ----------------
   logic [31:0] exp_q[$];
   bit          m_misalign = 1'b0;
   bit          prev_pending = 1'b0;
   logic [31:0] prev_addr = '0;

   function automatic void start_stream(input logic [31:0] target);
      exp_q.delete();
      for (int i = 0; i < SEG_LEN; i++) begin
         exp_q.push_back(target + 32'(4 * i));
      end
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         m_misalign   = 1'b0;
         prev_pending = 1'b0;
         start_stream(RESET_PC);
      end else begin
         if (bus.inst_valid && bus.inst_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pop_unexpected: got pc %h, expected no instruction (t=%0t)",
                        bus.inst_pc, $time);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("pop_pc", bus.inst_pc, e);
               check("pop_inst", bus.inst, mem_word(e));
            end
         end
         if (prev_pending) begin
            check("req_hold", 32'(bus.imem_req), 32'd1);
            check("addr_hold", bus.imem_addr, prev_addr);
         end
         if (bus.redirect) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) m_misalign = 1'b1;
            exp_q.delete();
            if (!m_misalign) start_stream(bus.redirect_pc);
`else
            start_stream({bus.redirect_pc[31:2], 2'b00});
`endif
         end
         prev_pending = bus.imem_req && !bus.imem_ack;
         prev_addr    = bus.imem_addr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic apply_reset();
      reset           = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_ack    = 1'b0;
      bus.inst_ready  = 1'b0;
      repeat (2) tick();
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, RESET_PC);
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef IFETCH_MISALIGN_CHECK_EN
      check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
      reset = 1'b0;
   endtask

   initial begin
      bit ok;
      int gap;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_ack    = 1'b0;
      bus.inst_ready  = 1'b0;

      // Back-to-back fetch with same-cycle ack.
      apply_reset();
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b1;
      tick();
      check("t1_req", 32'(bus.imem_req), 32'd1);
      check("t1_addr0", bus.imem_addr, 32'h100);
      tick();
      check("t1_addr1", bus.imem_addr, 32'h104);
      check("t1_pc0", bus.inst_pc, 32'h100);
      tick();
      check("t1_addr2", bus.imem_addr, 32'h108);
      check("t1_pc1", bus.inst_pc, 32'h104);

      // FIFO fills, fetch stalls, then resumes without gap.
      apply_reset();
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b0;
      repeat (3) tick();
      check("t2_req_stall", 32'(bus.imem_req), 32'd0);
      check("t2_valid", 32'(bus.inst_valid), 32'd1);
      check("t2_head", bus.inst_pc, 32'h100);
      tick();
      check("t2_req_still", 32'(bus.imem_req), 32'd0);
      bus.inst_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
         tick();
         if (bus.imem_req) ok = 1'b1;
      end
      check("t2_resume", 32'(ok), 32'd1);
      check("t2_addr", bus.imem_addr, 32'h108);
      repeat (3) tick();

      // Redirect while a delayed ack is pending.
      apply_reset();
      bus.inst_ready = 1'b1;
      tick();
      check("t3_addr", bus.imem_addr, 32'h100);
      tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h200;
      tick();
      bus.redirect = 1'b0;
      check("t3_drop_req", 32'(bus.imem_req), 32'd1);
      check("t3_drop_addr", bus.imem_addr, 32'h100);
      check("t3_drop_valid", 32'(bus.inst_valid), 32'd0);
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      check("t3_idle_req", 32'(bus.imem_req), 32'd0);
      check("t3_idle_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      check("t3_new_req", 32'(bus.imem_req), 32'd1);
      check("t3_new_addr", bus.imem_addr, 32'h200);
      bus.imem_ack = 1'b1;
      repeat (3) tick();

      // Redirect in the same cycle as an ack.
      apply_reset();
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b1;
      repeat (2) tick();
      check("t4_addr", bus.imem_addr, 32'h104);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h300;
      tick();
      bus.redirect = 1'b0;
      check("t4_req", 32'(bus.imem_req), 32'd0);
      check("t4_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      check("t4_new_addr", bus.imem_addr, 32'h300);
      repeat (3) tick();

      // Reset while a request is outstanding, late ack afterwards.
      apply_reset();
      bus.inst_ready = 1'b1;
      tick();
      check("t5_busy", 32'(bus.imem_req), 32'd1);
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      bus.imem_ack = 1'b1;
      check("t5_req", 32'(bus.imem_req), 32'd0);
      check("t5_valid", 32'(bus.inst_valid), 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      check("t5_restart", 32'(bus.imem_req), 32'd1);
      check("t5_addr", bus.imem_addr, RESET_PC);
      check("t5_empty", 32'(bus.inst_valid), 32'd0);

`ifdef IFETCH_MISALIGN_CHECK_EN
      // Misaligned redirect stops fetching until reset.
      apply_reset();
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b1;
      repeat (2) tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h302;
      tick();
      bus.redirect = 1'b0;
      check("t6_misalign", 32'(fetch_misalign), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_req", 32'(bus.imem_req), 32'd0);
         check("t6_valid", 32'(bus.inst_valid), 32'd0);
         check("t6_sticky", 32'(fetch_misalign), 32'd1);
      end
`endif

      // Randomized run, checked by the stream monitor.
      apply_reset();
      n_pops = 0;
      gap    = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.inst_ready = ($urandom_range(0, 9) < 7);
         bus.imem_ack   = bus.imem_req ? ($urandom_range(0, 9) < 6)
                                       : ($urandom_range(0, 9) == 0);
         if (($urandom_range(0, 15) == 0) || (gap >= 40)) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
`ifndef IFETCH_MISALIGN_CHECK_EN
            bus.redirect_pc = bus.redirect_pc | 32'($urandom_range(0, 3));
`endif
            gap = 0;
         end else begin
            bus.redirect = 1'b0;
            gap++;
         end
         reset = ($urandom_range(0, 299) == 0);
         if (reset) gap = 0;
         tick();
      end
      reset        = 1'b0;
      bus.redirect = 1'b0;
      bus.imem_ack = 1'b0;
      tick();
      n_cmp++;
      if (n_pops < 200) begin
         n_err++;
         $display("FAIL rand_progress: got %0d instructions, expected at least 200", n_pops);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
